hcsr04_echo_gen: RTL

HC-SR04 sensor emulator: the responder side of the ultrasonic trig/echo protocol. It watches a trig line, validates the trig pulse width, waits a fixed burst delay, then drives an echo pulse whose width in microseconds is the programmed distance length. It sits in the test and hardware-in-loop fabric, so the hcsr04 driver can be exercised on-board without a physical sensor.

---
 rtl/hcsr04_pkg.sv | 29 ++
 rtl/us_tick.sv | 30 +++
 rtl/hcsr04_echo_gen.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/hcsr04_pkg.sv
// Shared definitions for the HC-SR04 echo emulator: state encoding,
// microsecond counter width and the phase-end helper.
package hcsr04_pkg;

    localparam int STATE_LEN  = 3;
    localparam int US_CNT_LEN = 16;

    localparam logic [STATE_LEN-1:0] IDLE    = 3'd0;
    localparam logic [STATE_LEN-1:0] TRIG_HI = 3'd1;
    localparam logic [STATE_LEN-1:0] BURST   = 3'd2;
    localparam logic [STATE_LEN-1:0] ECHO    = 3'd3;
    localparam logic [STATE_LEN-1:0] HOLDOFF = 3'd4;

    typedef enum logic [STATE_LEN-1:0] {
        ST_IDLE    = IDLE,
        ST_TRIG_HI = TRIG_HI,
        ST_BURST   = BURST,
        ST_ECHO    = ECHO,
        ST_HOLDOFF = HOLDOFF
    } state_t;

    // True when the tick about to be counted brings cnt up to target.
    // Done one bit wider so a full-scale target cannot wrap.
    function automatic logic is_last_tick(input logic [US_CNT_LEN-1:0] cnt,
                                          input logic [US_CNT_LEN-1:0] target);
        return ({1'b0, cnt} + (US_CNT_LEN+1)'(1)) == {1'b0, target};
    endfunction

endpackage

// File: rtl/us_tick.sv
// Clearable divide-by-TICK_DIV counter. tick is high for one cycle every
// TICK_DIV cycles; the first tick is the TICK_DIV-th cycle after clr drops.
module us_tick #(
    parameter int unsigned TICK_DIV = 50
) (
    input  logic clk50M,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q;

    // Free-running divider, restarted by clr so each FSM phase is tick-aligned.
    always_ff @(posedge clk50M) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (cnt_q == CW'(TICK_DIV - 1)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Decoded from the counter register only, so it is glitch-free.
    assign tick = (cnt_q == CW'(TICK_DIV - 1));

endmodule

// File: rtl/hcsr04_echo_gen.sv
// HC-SR04 sensor emulator: validates the trig pulse width, waits the burst
// delay, then drives an echo of dist_len microseconds, followed by a guard
// holdoff. Optional macro HCSR04_ECHO_TIMEOUT_EN replaces a zero or
// over-range length with the no-target TIMEOUT_US echo.
module hcsr04_echo_gen
    import hcsr04_pkg::*;
#(
    parameter int unsigned CAP_LEN     = 16,
    parameter int unsigned TICK_DIV    = 50,
    parameter int unsigned TRIG_MIN_US = 10,
    parameter int unsigned BURST_US    = 200,
    parameter int unsigned TIMEOUT_US  = 38000,
    parameter int unsigned GUARD_US    = 1000
) (
    input  logic               clk50M,
    input  logic               rst,
    input  logic               sig_trig,
    input  logic [CAP_LEN-1:0] dist_len,
    output logic               sig_len,
    output logic               busy,
    output logic               echo_done,
    output logic               short_trig
);

`ifdef HCSR04_ECHO_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [US_CNT_LEN-1:0] TRIG_MIN_LEN = US_CNT_LEN'(TRIG_MIN_US);
    localparam logic [US_CNT_LEN-1:0] BURST_LEN    = US_CNT_LEN'(BURST_US);
    localparam logic [US_CNT_LEN-1:0] TIMEOUT_LEN  = US_CNT_LEN'(TIMEOUT_US);
    localparam logic [US_CNT_LEN-1:0] GUARD_LEN    = US_CNT_LEN'(GUARD_US);

    logic                  trig_meta_q;
    logic                  trig_s_q;
    state_t                state_q, state_d;
    logic [US_CNT_LEN-1:0] us_cnt_q, us_cnt_d;
    logic [CAP_LEN-1:0]    len_q, len_d;
    logic                  sig_len_q, sig_len_d;
    logic                  busy_q;
    logic                  echo_done_q, echo_done_d;
    logic                  short_trig_q, short_trig_d;
    logic [US_CNT_LEN-1:0] len_eff;
    logic [US_CNT_LEN-1:0] trig_cnt_eff;
    logic                  tick;
    logic                  tick_clr;

    us_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_us_tick (
        .clk50M (clk50M),
        .rst    (rst),
        .clr    (tick_clr),
        .tick   (tick)
    );

    // Echo length actually played; the no-target clamp only exists when enabled.
    always_comb begin
        len_eff = US_CNT_LEN'(len_q);
        if (TIMEOUT_EN && ((len_q == '0) || (32'(len_q) > 32'(TIMEOUT_US)))) begin
            len_eff = TIMEOUT_LEN;
        end
    end

    // Trig width including a tick landing on this very cycle, saturating at
    // the minimum, so a trig that falls on the qualifying tick is accepted.
    always_comb begin
        trig_cnt_eff = us_cnt_q;
        if (tick && (us_cnt_q < TRIG_MIN_LEN)) begin
            trig_cnt_eff = us_cnt_q + 1'b1;
        end
    end

    // Next-state and output decisions; every state change restarts the
    // microsecond timebase so each phase is an exact multiple of TICK_DIV.
    always_comb begin
        state_d      = state_q;
        us_cnt_d     = us_cnt_q;
        len_d        = len_q;
        sig_len_d    = sig_len_q;
        echo_done_d  = 1'b0;
        short_trig_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig_s_q) begin
                    state_d = ST_TRIG_HI;
                end
            end
            ST_TRIG_HI: begin
                if (!trig_s_q) begin
                    if (trig_cnt_eff >= TRIG_MIN_LEN) begin
                        len_d   = dist_len;
                        state_d = ST_BURST;
                    end else begin
                        short_trig_d = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end else begin
                    us_cnt_d = trig_cnt_eff;
                end
            end
            ST_BURST: begin
                if (tick) begin
                    if (is_last_tick(us_cnt_q, BURST_LEN)) begin
                        if (len_eff == '0) begin
                            echo_done_d = 1'b1;
                            state_d     = ST_HOLDOFF;
                        end else begin
                            sig_len_d = 1'b1;
                            state_d   = ST_ECHO;
                        end
                    end else begin
                        us_cnt_d = us_cnt_q + 1'b1;
                    end
                end
            end
            ST_ECHO: begin
                if (tick) begin
                    if (is_last_tick(us_cnt_q, len_eff)) begin
                        sig_len_d   = 1'b0;
                        echo_done_d = 1'b1;
                        state_d     = ST_HOLDOFF;
                    end else begin
                        us_cnt_d = us_cnt_q + 1'b1;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (tick) begin
                    if (is_last_tick(us_cnt_q, GUARD_LEN)) begin
                        state_d = ST_IDLE;
                    end else begin
                        us_cnt_d = us_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                sig_len_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
        if (state_d != state_q) begin
            us_cnt_d = '0;
        end
    end

    assign tick_clr = (state_d != state_q);

    // State, synchronizer and registered outputs.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            trig_meta_q  <= 1'b0;
            trig_s_q     <= 1'b0;
            state_q      <= ST_IDLE;
            us_cnt_q     <= '0;
            len_q        <= '0;
            sig_len_q    <= 1'b0;
            busy_q       <= 1'b0;
            echo_done_q  <= 1'b0;
            short_trig_q <= 1'b0;
        end else begin
            trig_meta_q  <= sig_trig;
            trig_s_q     <= trig_meta_q;
            state_q      <= state_d;
            us_cnt_q     <= us_cnt_d;
            len_q        <= len_d;
            sig_len_q    <= sig_len_d;
            busy_q       <= (state_d != ST_IDLE);
            echo_done_q  <= echo_done_d;
            short_trig_q <= short_trig_d;
        end
    end

    assign sig_len    = sig_len_q;
    assign busy       = busy_q;
    assign echo_done  = echo_done_q;
    assign short_trig = short_trig_q;

endmodule
